// File: rtl/fft_pkg.sv
// fft_pkg: shared types, width defaults and index helpers for the FFT cores and their loaders.
package fft_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FFT_POINTS = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int unsigned bitrev(input int unsigned v, input int bits);
        int unsigned r;
        r = 0;
        for (int i = 0; i < bits; i++)
            if (v[i]) r[bits-1-i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one frame of sample registers with an indexed write port,
// a whole-bank clear and a flat sign-extended read bus.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int N_POINTS = FFT_POINTS,
    parameter int IN_W     = SAMPLE_W,
    parameter int OUT_W    = SAMPLE_W,
    parameter int IDX_W    = clog2(N_POINTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      we,
    input  logic [IDX_W-1:0]          idx,
    input  logic [IN_W-1:0]           din,
    output logic [N_POINTS*OUT_W-1:0] dout
);

    logic [IN_W-1:0] mem [N_POINTS];

    // A write wins over a clear; the top never asks for both on one bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_POINTS; k++) mem[k] <= '0;
        end else if (we) begin
            mem[idx] <= din;
        end else if (clr) begin
            for (int k = 0; k < N_POINTS; k++) mem[k] <= '0;
        end
    end

    for (genvar k = 0; k < N_POINTS; k++) begin : g_rd
        assign dout[k*OUT_W +: OUT_W] = OUT_W'($signed(mem[k]));
    end

endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: assembles a valid/ready sample stream into N-point frames
// held in a ping-pong pair of banks and presents each frame as one flat bus.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int N_POINTS    = FFT_POINTS,
    parameter int IN_W        = SAMPLE_W,
    parameter int OUT_W       = SAMPLE_W,
    parameter int BIT_REVERSE = 0,
    parameter int CNT_W       = 16
) (
    input  logic                      clk_100,
    input  logic                      reset_all_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_W-1:0]           s_data,
    input  logic                      s_last,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [N_POINTS*OUT_W-1:0] frame_data,
    output logic                      err_len,
    output logic [CNT_W-1:0]          frame_cnt
);

    localparam int LOG2N = clog2(N_POINTS);

    bank_state_t              state [2];
    logic                     wr_sel;
    logic                     rd_sel;
    logic [LOG2N-1:0]         wr_idx;
    logic [LOG2N-1:0]         slot;
    logic                     accept;
    logic                     consume;
    logic                     last_slot;
    logic                     early;
    logic [N_POINTS*OUT_W-1:0] bank_data [2];

    assign s_ready     = state[wr_sel] != BANK_FULL;
    assign frame_valid = state[rd_sel] == BANK_FULL;
    assign frame_data  = bank_data[rd_sel];
    assign accept      = s_valid && s_ready;
    assign consume     = frame_valid && frame_ready;
    assign last_slot   = wr_idx == LOG2N'(N_POINTS - 1);
    assign early       = accept && s_last && !last_slot;
    assign slot        = (BIT_REVERSE != 0) ? LOG2N'(bitrev(32'(wr_idx), LOG2N)) : wr_idx;

    // A consumed bank is FULL and a written bank is not, so both updates may land in one cycle.
    always_ff @(posedge clk_100 or negedge reset_all_n) begin
        if (!reset_all_n) begin
            state[0]  <= BANK_EMPTY;
            state[1]  <= BANK_EMPTY;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            err_len   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            err_len <= early;
            if (consume) begin
                state[rd_sel] <= BANK_EMPTY;
                rd_sel        <= ~rd_sel;
                frame_cnt     <= frame_cnt + CNT_W'(1);
            end
            if (accept) begin
                state[wr_sel] <= last_slot ? BANK_FULL : early ? BANK_EMPTY : BANK_FILLING;
                wr_idx        <= s_last ? '0 : wr_idx + LOG2N'(1);
                if (last_slot) wr_sel <= ~wr_sel;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .N_POINTS (N_POINTS),
            .IN_W     (IN_W),
            .OUT_W    (OUT_W),
            .IDX_W    (LOG2N)
        ) u_bank (
            .clk   (clk_100),
            .rst_n (reset_all_n),
            .clr   (consume && rd_sel == 1'(b)),
            .we    (accept && wr_sel == 1'(b)),
            .idx   (slot),
            .din   (s_data),
            .dout  (bank_data[b])
        );
    end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Parametrised streaming front end for the FFT cores.
- Accepts real samples one per cycle over a valid/ready stream and assembles them into N-point frames in a ping-pong (two-bank) buffer.
- Each completed frame is presented as one flat parallel bus, optionally in bit-reversed order, with a valid/ready handshake.
- Replaces hand-driven x0..x31 loading with a reusable loader for any power-of-two FFT size and sample width.

Parameters:
- N_POINTS, 32, frame length; power of two, 4..256. LOG2N = log2(N_POINTS) is a derived localparam.
- IN_W, 16, input sample width, signed two's complement.
- OUT_W, 16, output sample width; must be >= IN_W. Samples are sign-extended from IN_W to OUT_W.
- BIT_REVERSE, 0, frame ordering. 0: natural order. 1: sample n is placed at slot bitrev(n) over LOG2N bits.
- CNT_W, 16, width of the delivered-frame counter.

Ports:
- clk_100  in  1  sole clock; all logic on the rising edge.
- reset_all_n  in  1  reset, asynchronous assert, active low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample this cycle.
- s_data  in  IN_W  signed input sample.
- s_last  in  1  producer marks the final sample of a frame.
- frame_valid  out  1  a complete frame is presented.
- frame_ready  in  1  consumer accepts the presented frame.
- frame_data  out  N_POINTS*OUT_W  slot k occupies bits [k*OUT_W +: OUT_W].
- err_len  out  1  one-cycle pulse when s_last arrives early.
- frame_cnt  out  CNT_W  count of frames delivered; wraps modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous, when reset_all_n = 0:
  - Both banks empty; wr_sel = 0, rd_sel = 0, wr_idx = 0.
  - Bank storage cleared to 0.
  - s_ready = 1, frame_valid = 0, frame_data = 0, err_len = 0, frame_cnt = 0.
  - Reset mid-frame discards all partial and full frames.
- State per bank: EMPTY, FILLING, FULL. The write bank is selected by wr_sel, the read bank by rd_sel.
- s_ready = (state[wr_sel] != FULL). It is derived from registered state only, never from s_valid.
- Accept: an input handshake occurs when s_valid && s_ready.
  - The sample is stored at slot (BIT_REVERSE ? bitrev(wr_idx) : wr_idx) of bank wr_sel.
  - The bank state becomes FILLING.
  - wr_idx increments.
- Frame complete: on an accept with wr_idx = N_POINTS-1 (s_last may be 0 or 1):
  - The bank becomes FULL and wr_idx wraps to 0.
  - wr_sel toggles so the producer moves to the other bank.
  - If that bank is FULL, s_ready drops and stays low until it drains.
- Early s_last: an accept with s_last = 1 and wr_idx < N_POINTS-1:
  - The sample is stored, err_len pulses for 1 cycle, and wr_idx returns to 0.
  - The bank returns to EMPTY (partial frame dropped).
  - wr_sel is unchanged and frame_cnt is unchanged.
- Output:
  - frame_valid = (state[rd_sel] == FULL).
  - frame_data is the registered contents of bank rd_sel, sign-extended.
  - frame_data is stable while frame_valid && !frame_ready.
  - Latency: frame_valid rises on the cycle after the accept of sample N_POINTS-1.
- Consume: when frame_valid && frame_ready:
  - Bank rd_sel becomes EMPTY, rd_sel toggles, and frame_cnt increments.
- Simultaneous events:
  - A consume of one bank and completion of the other in the same cycle are both honoured.
  - A consume that frees the bank wr_sel points at raises s_ready on the next cycle.
  - Throughput is one sample per cycle sustained, provided the consumer takes each frame within N_POINTS cycles.
- frame_data while frame_valid = 0 is don't-care. Verification checks it only when frame_valid = 1.

Decomposition:
- Shared package fft_pkg holds:
  - the bank-state enumeration (EMPTY/FILLING/FULL);
  - the clog2 and bitrev helper functions;
  - the default width constants (16-bit sample, 32 points) common with the FFT cores.
- One sub-module, fft_frame_bank: one N_POINTS x IN_W register bank with a write port (enable, index, data), a clear, and a flat sign-extended read bus. It is instantiated twice.
- Control FSM, wr_idx counter and frame_cnt stay in the top.

Test Plan:
- Impulse: N=32, stream 256 then 31 zeros, BIT_REVERSE=0.
  - frame_valid rises 1 cycle after the 32nd accept.
  - Slot 0 = 256, all others 0.
  - frame_cnt = 1 after the consume.
- Ordering: N=8, BIT_REVERSE=1, stream 0..7.
  - Slots 0..7 read 0, 4, 2, 6, 1, 5, 3, 7.
- Backpressure: frame_ready held 0, continuous s_valid for 3 frames.
  - Two frames buffer, then s_ready = 0 at the 65th sample.
  - Releasing frame_ready for one cycle raises s_ready the next cycle; no sample is lost or duplicated.
- Early s_last on the 10th sample:
  - err_len pulses once, no frame_valid, frame_cnt unchanged.
  - The next 32 samples form a clean frame.
- Sign extension: IN_W=12, OUT_W=16, sample 12'h800.
  - The slot reads 16'hF800.
- Reset mid-frame: assert reset_all_n low after 20 samples.
  - All outputs return to reset values immediately, asynchronously.
  - The next full frame is delivered correctly.
